adt7420_temp_reader: RTL
========================

Name: adt7420_temp_reader

Overview:
- Upstream neighbour of the seven-segment temperature display.
- Periodically reads the on-board ADT7420 temperature sensor over I2C using the power-up pointer register 0x00, so no pointer write is needed.
- Converts the 13-bit reading to whole degrees Celsius clamped to 0..99 and presents it as an 8-bit value for the display's temp_data_i.
- Single-master bus; no clock stretching, no arbitration.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency
SCL_FREQ_HZ, 100_000, I2C SCL rate; quarter-period divider QTR_DIV = CLK_FREQ_HZ/(4*SCL_FREQ_HZ) = 250
SAMPLE_CYC, 25_000_000, clocks between transaction starts (250 ms, longer than the 240 ms conversion time)
DEV_ADDR, 7'h4B, 7-bit sensor address

Ports:
clk_100MHz_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
scl_oe_o  out  1  1 = pull SCL low, 0 = release; top level builds the open-drain buffer
sda_oe_o  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  SDA pad input; synchronised internally with 2 flops
temp_data_o  out  8  temperature, 0..99 degrees C, unsigned
temp_valid_o  out  1  one-cycle pulse when temp_data_o updates
busy_o  out  1  high from START through end of STOP
ack_err_o  out  1  set on address NACK, cleared by next successful read

Behaviour:
- Reset (async assert, sync release): scl_oe_o=0, sda_oe_o=0, temp_data_o=0, temp_valid_o=0, busy_o=0, ack_err_o=0, state=IDLE, counters=0. Assertion mid-transaction releases both lines immediately.
- Quarter tick: divider counts 0..QTR_DIV-1 and emits qtick on the terminal count, only while busy. Each SCL bit = 4 qticks: q0 SCL low/drive SDA, q1 low, q2 SCL released, q3 high. sda_i is sampled at the end of q3.
- Sample timer: counts 0..SAMPLE_CYC-1 and free-runs. On wrap in IDLE → START. A wrap while busy is ignored, with no queueing. First transaction starts SAMPLE_CYC cycles after reset release.
- FSM states:
  - IDLE: lines released.
  - START: SDA low while SCL high, then SCL low.
  - ADDR: shift {DEV_ADDR,1'b1}=0x97, MSB first, 8 bits.
  - ADDR_ACK: release SDA, sample. 0 → RD_MSB; 1 → set ack_err_o, go to STOP.
  - RD_MSB: 8 bits in, MSB first.
  - M_ACK: drive SDA low for one bit.
  - RD_LSB: 8 bits in.
  - M_NACK: release SDA for one bit.
  - STOP: SDA low, SCL high, then SDA released. On success, go to UPDATE; otherwise go to IDLE.
  - UPDATE: one cycle → IDLE.
- Conversion in UPDATE:
  - raw = {MSB,LSB}; t = signed raw[15:7] (9 bits, integer degrees, truncated toward −inf).
  - t<0 → 0; t>99 → 99; else t[7:0].
  - temp_data_o registers the result, temp_valid_o pulses 1 cycle, ack_err_o clears.
- Address NACK: temp_data_o holds its previous value, no valid pulse, retry at the next timer wrap.
- busy_o = (state != IDLE).
- Transaction length ≈ 29 SCL bits ≈ 290 µs at defaults.

Decomposition:
- Package adt7420_pkg:
  - state enum (IDLE, START, ADDR, ADDR_ACK, RD_MSB, M_ACK, RD_LSB, M_NACK, STOP, UPDATE)
  - ADT7420_ADDR = 7'h4B
  - TEMP_MAX = 8'd99
  - READ_BIT = 1'b1
- Sub-module i2c_qtick_gen: parameterised quarter-period divider with enable; outputs qtick and a 2-bit phase.

Test Plan:
- Sensor model ACKs and returns 0x0C,0x80 → bus shows 0x97, master ACK after byte 1, NACK after byte 2, STOP. temp_data_o=25, one temp_valid_o pulse, ack_err_o=0.
- Returns 0xFF,0x80 (−1 °C) → temp_data_o=0. Returns 0x32,0x00 (100 °C) → temp_data_o=99. Returns 0x31,0x80 (99 °C) → 99.
- Sensor NACKs the address → STOP issued right after the ACK slot, ack_err_o=1, temp_data_o unchanged, no valid pulse. Next period ACKs with 0x0A,0x00 → temp_data_o=20, ack_err_o=0.
- Check SCL period = 1000 clocks, SDA changes only while SCL low except START/STOP, and transaction starts spaced exactly SAMPLE_CYC (bench override 5000).
- Assert rst_n_i during RD_MSB → scl_oe_o=sda_oe_o=0 the same cycle, outputs at reset values. After release, the next transaction starts SAMPLE_CYC later.
- Hold sda_i low on every sampled read bit (bus fault model returns 0x00,0x00) → temp_data_o=0 with valid pulse and no hang; busy_o drops after STOP.

Source files
------------

// File: rtl/adt7420_pkg.sv
// Shared types and constants for the ADT7420 temperature reader.
package adt7420_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    RD_MSB,
    M_ACK,
    RD_LSB,
    M_NACK,
    STOP,
    UPDATE
  } state_e;

  localparam logic [6:0] ADT7420_ADDR = 7'h4B;
  localparam logic [7:0] TEMP_MAX     = 8'd99;
  localparam logic       READ_BIT     = 1'b1;

  // Sensor word -> whole degrees C, clamped to the display range 0..TEMP_MAX.
  // raw[15:7] is the signed integer part (1 LSB = 1 degree, floor rounding).
  function automatic logic [7:0] raw_to_degc(input logic [15:0] raw);
    logic signed [8:0] t;
    logic [7:0]        res;
    t = $signed(raw[15:7]);
    if (t < 9'sd0) begin
      res = 8'd0;
    end else if (t > $signed({1'b0, TEMP_MAX})) begin
      res = TEMP_MAX;
    end else begin
      res = t[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-bit timebase for the I2C master: qtick marks the last clock of
// each quarter, phase_o is the quarter index (0..3) within the current bit.
module i2c_qtick_gen #(
  parameter int unsigned QTR_DIV = 250
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  output logic       qtick_o,
  output logic [1:0] phase_o
);

  localparam int unsigned CNT_W = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       phase_q;

  assign qtick_o = en_i && (cnt_q == CNT_W'(QTR_DIV - 1));
  assign phase_o = phase_q;

  // Divider and quarter counter; both restart from zero whenever disabled.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else if (!en_i) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else if (qtick_o) begin
      cnt_q   <= '0;
      phase_q <= phase_q + 2'd1;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adt7420_temp_reader.sv
// Periodic ADT7420 reader: issues a 2-byte I2C read from the power-up
// temperature register, converts it to 0..99 degrees C and publishes it.
// rst_n_i is expected to be released synchronously to the clock upstream.
module adt7420_temp_reader
  import adt7420_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned SCL_FREQ_HZ = 100_000,
  parameter int unsigned SAMPLE_CYC  = 25_000_000,
  parameter logic [6:0]  DEV_ADDR    = ADT7420_ADDR
) (
  input  logic       clk_100MHz_i,
  input  logic       rst_n_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  input  logic       sda_i,
  output logic [7:0] temp_data_o,
  output logic       temp_valid_o,
  output logic       busy_o,
  output logic       ack_err_o
);

  localparam int unsigned QTR_DIV   = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
  localparam int unsigned TMR_W     = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam logic [7:0]  ADDR_BYTE = {DEV_ADDR, READ_BIT};

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      shift_q, shift_d;
  logic             rd_ok_q, rd_ok_d;
  logic [7:0]       temp_q, temp_d;
  logic             valid_q, valid_d;
  logic             ack_err_q, ack_err_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;
  logic [TMR_W-1:0] timer_q;
  logic             sda_meta_q, sda_sync_q;
  logic             qtick, timer_wrap, bit_end, last_bit;
  logic [1:0]       phase;

  i2c_qtick_gen #(
    .QTR_DIV (QTR_DIV)
  ) u_qtick (
    .clk_i   (clk_100MHz_i),
    .rst_n_i (rst_n_i),
    .en_i    (state_q != IDLE),
    .qtick_o (qtick),
    .phase_o (phase)
  );

  assign timer_wrap = (timer_q == TMR_W'(SAMPLE_CYC - 1));
  assign bit_end    = qtick && (phase == 2'd3);
  assign last_bit   = (bit_cnt_q == 3'd7);

  // Free-running sample timer; its wrap launches a read only when idle.
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q <= '0;
    end else if (timer_wrap) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Two-flop synchroniser for the SDA pad; resets to the idle-high level.
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
    end
  end

  // Next-state and bus-line decode. Data bits: SCL low in q0/q1, released in
  // q2/q3, SDA set at q0 and sampled on the last clock of q3.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rd_ok_d   = rd_ok_q;
    temp_d    = temp_q;
    ack_err_d = ack_err_q;
    valid_d   = 1'b0;
    scl_oe_d  = 1'b0;
    sda_oe_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (timer_wrap) state_d = START;
      end
      START: begin
        // SDA falls while SCL is still high, then SCL is pulled low.
        scl_oe_d = phase[1];
        sda_oe_d = 1'b1;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        scl_oe_d = ~phase[1];
        sda_oe_d = ~ADDR_BYTE[3'd7 - bit_cnt_q];
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) state_d = ADDR_ACK;
        end
      end
      ADDR_ACK: begin
        scl_oe_d = ~phase[1];
        if (bit_end) begin
          rd_ok_d = ~sda_sync_q;
          if (sda_sync_q) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else begin
            state_d   = RD_MSB;
          end
        end
      end
      RD_MSB, RD_LSB: begin
        scl_oe_d = ~phase[1];
        if (bit_end) begin
          shift_d   = {shift_q[14:0], sda_sync_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) state_d = (state_q == RD_MSB) ? M_ACK : M_NACK;
        end
      end
      M_ACK: begin
        scl_oe_d = ~phase[1];
        sda_oe_d = 1'b1;
        if (bit_end) state_d = RD_LSB;
      end
      M_NACK: begin
        scl_oe_d = ~phase[1];
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // SDA held low until SCL is high, then released in the last quarter.
        scl_oe_d = ~phase[1];
        sda_oe_d = (phase != 2'd3);
        if (bit_end) state_d = rd_ok_q ? UPDATE : IDLE;
      end
      UPDATE: begin
        temp_d    = raw_to_degc(shift_q);
        valid_d   = 1'b1;
        ack_err_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state, datapath and registered (glitch-free) bus drivers.
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rd_ok_q   <= 1'b0;
      temp_q    <= '0;
      valid_q   <= 1'b0;
      ack_err_q <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rd_ok_q   <= rd_ok_d;
      temp_q    <= temp_d;
      valid_q   <= valid_d;
      ack_err_q <= ack_err_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign scl_oe_o     = scl_oe_q;
  assign sda_oe_o     = sda_oe_q;
  assign temp_data_o  = temp_q;
  assign temp_valid_o = valid_q;
  assign busy_o       = (state_q != IDLE);
  assign ack_err_o    = ack_err_q;

endmodule
